// File: rtl/complement_pipe_if.sv
`default_nettype none
// --------------------------------------------------------------------------
// complement_pipe_if: operand/result handshake bundle for complement_pipe.
// Rev 1.0
// --------------------------------------------------------------------------
interface complement_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_negz;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_negz, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_negz, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/complement_pipe.sv
`default_nettype none
// --------------------------------------------------------------------------
// complement_pipe: two-stage pass / one's / two's / sign-magnitude converter.
// Rev 1.0
// --------------------------------------------------------------------------
module complement_pipe #(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  complement_pipe_if.slave bus
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_SM   = 2'b11;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_inv;
  logic             s1_cin;
  logic             s1_ovf;
  logic             s1_negz;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_ovf;
  logic             s2_negz;
  logic             s2_zero;

  logic             s2_adv;
  logic             s1_adv;
  logic [WIDTH-1:0] inv_next;
  logic             cin_next;
  logic             is_most_neg;
  logic [WIDTH-1:0] sum;

  assign s2_adv      = !s2_valid || bus.out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign is_most_neg = (bus.in_data == MOST_NEG);

  // Every negating mode is expressed as invert-then-increment so S2 holds a single adder.
  always_comb begin
    inv_next = bus.in_data;
    cin_next = 1'b0;
    case (bus.in_mode)
      MODE_ONES: inv_next = ~bus.in_data;
      MODE_NEG: begin
        inv_next = ~bus.in_data;
        cin_next = 1'b1;
      end
      MODE_SM: begin
        if (bus.in_data[WIDTH-1]) begin
          inv_next = ~{1'b0, bus.in_data[WIDTH-2:0]};
          cin_next = 1'b1;
        end
      end
      MODE_PASS: inv_next = bus.in_data;
      default:   inv_next = bus.in_data;
    endcase
  end

  assign sum = s1_inv + {{(WIDTH-1){1'b0}}, s1_cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inv   <= '0;
      s1_cin   <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_negz  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_inv  <= inv_next;
        s1_cin  <= cin_next;
        s1_ovf  <= is_most_neg && (bus.in_mode == MODE_NEG);
        s1_negz <= is_most_neg && (bus.in_mode == MODE_SM);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
      s2_negz  <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sum;
        s2_ovf  <= s1_ovf;
        s2_negz <= s1_negz;
        s2_zero <= (sum == '0);
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_ovf   = s2_ovf;
  assign bus.out_negz  = s2_negz;
  assign bus.out_zero  = s2_zero;

endmodule
`default_nettype wire

// File: tb/tb_complement_pipe.sv
`default_nettype none
// --------------------------------------------------------------------------
// tb_complement_pipe: vector table, corner sequences and random traffic
// against a queue-based arithmetic reference. Rev 1.0
// --------------------------------------------------------------------------
module tb_complement_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  complement_pipe_if #(.WIDTH(8))  bus8  ();
  complement_pipe_if #(.WIDTH(16)) bus16 ();

  complement_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  complement_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] data;
    logic       ovf;
    logic       negz;
    logic       zero;
  } vec_t;

  // {data, ovf, negz, zero} expected per accepted input, in order
  logic [10:0] expq[$];
  logic        held_valid = 1'b0;
  logic [10:0] held_vec   = '0;

  function automatic logic [10:0] model(input logic [1:0] m, input logic [7:0] a);
    int  r;
    logic ovf;
    logic negz;
    ovf  = 1'b0;
    negz = 1'b0;
    case (m)
      2'd0: r = int'(a);
      2'd1: r = 255 - int'(a);
      2'd2: begin
        r   = (256 - int'(a)) % 256;
        ovf = (a == 8'd128);
      end
      default: begin
        if (a < 8'd128) r = int'(a);
        else begin
          r    = (256 - (int'(a) - 128)) % 256;
          negz = (a == 8'd128);
        end
      end
    endcase
    return {r[7:0], ovf, negz, (r == 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: the negedge sees the handshake that completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      held_valid <= 1'b0;
    end else begin
      if (held_valid) begin
        check("stall_valid", {31'd0, bus8.out_valid}, 32'd1);
        check("stall_hold", {21'd0, bus8.out_data, bus8.out_ovf, bus8.out_negz, bus8.out_zero},
              {21'd0, held_vec});
      end
      if (bus8.out_valid && bus8.out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_output: got %h with nothing outstanding", bus8.out_data);
        end else begin
          check("sb_result", {21'd0, bus8.out_data, bus8.out_ovf, bus8.out_negz, bus8.out_zero},
                {21'd0, expq.pop_front()});
        end
      end
      if (bus8.in_valid && bus8.in_ready)
        expq.push_back(model(bus8.in_mode, bus8.in_data));
      held_valid <= bus8.out_valid && !bus8.out_ready;
      held_vec   <= {bus8.out_data, bus8.out_ovf, bus8.out_negz, bus8.out_zero};
    end
  end

  // Presents one operand from posedge+1 and returns at posedge+1 after it was taken.
  task automatic send(input logic [1:0] m, input logic [7:0] a);
    bit taken = 1'b0;
    bus8.in_valid = 1'b1;
    bus8.in_mode  = m;
    bus8.in_data  = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %0d", bus8.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus8.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit empty = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !bus8.out_valid) begin
        empty = 1'b1;
        break;
      end
    end
    check("drain_empty", {31'd0, empty}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];
  bit   rand_done;

  initial begin
    vecs[0]  = '{2'd1, 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'd2, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'd2, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'd3, 8'h85, 8'hFB, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'd3, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'd3, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'd0, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'd1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'd3, 8'hFF, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'd2, 8'h7F, 8'h81, 1'b0, 1'b0, 1'b0};

    bus8.in_valid   = 1'b0;
    bus8.in_mode    = 2'd0;
    bus8.in_data    = 8'h00;
    bus8.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_mode   = 2'd0;
    bus16.in_data   = 16'h0000;
    bus16.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    check("reset_outputs", {21'd0, bus8.out_data, bus8.out_ovf, bus8.out_negz, bus8.out_zero}, 32'd0);

    // Single-transaction latency: visible after the second rising edge following acceptance.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].mode, vecs[i].a);
      bus8.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("vec_valid", {31'd0, bus8.out_valid}, 32'd1);
      check($sformatf("vec%0d", i),
            {21'd0, bus8.out_data, bus8.out_ovf, bus8.out_negz, bus8.out_zero},
            {21'd0, vecs[i].data, vecs[i].ovf, vecs[i].negz, vecs[i].zero});
      idle(1);
    end

    // Back-to-back streams at full rate.
    send(2'd2, 8'h01); send(2'd2, 8'h00); send(2'd2, 8'h80);
    send(2'd3, 8'h85); send(2'd3, 8'h05); send(2'd3, 8'h80);
    drain();

    // Backpressure: two accepted, then in_ready must drop and S2 must hold 0xF0.
    bus8.out_ready = 1'b0;
    fork
      begin
        send(2'd2, 8'h10); send(2'd2, 8'h11); send(2'd2, 8'h12); send(2'd2, 8'h13);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", {31'd0, bus8.in_ready}, 32'd0);
        check("bp_hold_data", {24'd0, bus8.out_data}, 32'h0000_00F0);
        @(posedge clk);
        #1 bus8.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full.
    bus8.out_ready = 1'b0;
    send(2'd1, 8'h33);
    send(2'd1, 8'h44);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("rst_pipe_full", {30'd0, bus8.out_valid, bus8.in_ready}, 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    check("midrst_outputs", {21'd0, bus8.out_data, bus8.out_ovf, bus8.out_negz, bus8.out_zero}, 32'd0);
    bus8.out_ready = 1'b1;
    idle(5);
    check("midrst_no_stale", {31'd0, bus8.out_valid}, 32'd0);

    // Random traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 400; t++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        bus8.in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus8.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    // Wider instance: most-negative negate and sign-magnitude.
    bus16.in_valid = 1'b1;
    bus16.in_mode  = 2'd2;
    bus16.in_data  = 16'h8000;
    @(posedge clk);
    #1;
    bus16.in_mode  = 2'd3;
    bus16.in_data  = 16'h8003;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    check("w16_neg_valid", {31'd0, bus16.out_valid}, 32'd1);
    check("w16_neg_min", {13'd0, bus16.out_data, bus16.out_ovf, bus16.out_negz, bus16.out_zero},
          {13'd0, 16'h8000, 3'b100});
    @(posedge clk);
    #1;
    check("w16_sm", {13'd0, bus16.out_data, bus16.out_ovf, bus16.out_negz, bus16.out_zero},
          {13'd0, 16'hFFFD, 3'b000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
